// File: rtl/ct_lsu_dcache_pkg.sv
// ct_lsu_dcache_pkg: shared encodings for the D-cache data bank arbiter
package ct_lsu_dcache_pkg;
  localparam int IDX_W_DEF = 11;
  localparam int RFL_BEATS = 4;
  localparam logic [1:0] ACC_IDLE = 2'd0;
  localparam logic [1:0] ACC_RD   = 2'd1;
  localparam logic [1:0] ACC_ST   = 2'd2;
  localparam logic [1:0] ACC_RFL  = 2'd3;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RFL   = 1'b1;
endpackage

// File: rtl/ct_lsu_dcache_data_arb_age.sv
// ct_lsu_dcache_data_arb_age: load starvation counter; ld_force raises load above store and refill start
//   clk, rst        : clock, sync active-high reset
//   ld_req, ld_gnt  : load handshake observed by the counter
//   ld_force        : load has been denied AGE_MAX consecutive cycles
module ct_lsu_dcache_data_arb_age #(
  parameter int AGE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic ld_force
);
  localparam int AW = $clog2(AGE_MAX + 1);
  logic [AW-1:0] age;
  always_ff @(posedge clk)
    age <= (rst | ~ld_req | ld_gnt) ? '0 : (age == AW'(AGE_MAX)) ? age : age + 1'b1;
  assign ld_force = ld_req & (age == AW'(AGE_MAX));
endmodule

// File: rtl/ct_lsu_dcache_data_arb.sv
// ct_lsu_dcache_data_arb: arbitrates refill/store/load onto one 32-bit D-cache data bank
//   forever_cpuclk, cpurst            : clock, sync active-high reset
//   rfl_*                             : refill request/grant, 4-beat burst write
//   st_*                              : store request/grant, byte-masked write
//   ld_*                              : load request/grant, read data 2 cycles after grant
//   data_*                            : registered SRAM controls, data_dout from the bank
//   CT_LSU_DCACHE_ARB_AGE_EN          : enables load aging (starved load beats store/refill start)
module ct_lsu_dcache_data_arb
  import ct_lsu_dcache_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int AGE_MAX = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             rfl_req,
  output logic             rfl_gnt,
  input  logic [IDX_W-1:0] rfl_idx,
  input  logic [31:0]      rfl_wdata,
  output logic             rfl_beat_vld,
  input  logic             st_req,
  output logic             st_gnt,
  input  logic [IDX_W-1:0] st_idx,
  input  logic [31:0]      st_wdata,
  input  logic [3:0]       st_be,
  input  logic             ld_req,
  output logic             ld_gnt,
  input  logic [IDX_W-1:0] ld_idx,
  output logic             ld_rdata_vld,
  output logic [31:0]      ld_rdata,
  input  logic [31:0]      data_dout,
  output logic             data_sel_b,
  output logic             data_gwen_b,
  output logic [3:0]       data_wen_b,
  output logic [IDX_W-1:0] data_idx,
  output logic [31:0]      data_din,
  output logic             data_gateclk_en
);
  logic [0:0]       state;
  logic [1:0]       beat;
  logic [IDX_W-3:0] base;
  logic             rd_p1;
  logic             ld_force;
  logic             go;
  logic [1:0]       acc;
  logic [IDX_W-1:0] acc_idx;
  logic             unused;

`ifdef CT_LSU_DCACHE_ARB_AGE_EN
  ct_lsu_dcache_data_arb_age #(.AGE_MAX(AGE_MAX)) u_age (
    .clk      (forever_cpuclk),
    .rst      (cpurst),
    .ld_req   (ld_req),
    .ld_gnt   (ld_gnt),
    .ld_force (ld_force)
  );
`else
  assign ld_force = 1'b0;
`endif

  // line offset bits of rfl_idx are replaced by the beat number
  assign unused = ^rfl_idx[1:0] ^ (AGE_MAX > 0);

  // grants are only issued from IDLE; an active burst cannot be preempted
  always_comb begin
    go           = (state == ST_IDLE) & ~cpurst;
    rfl_gnt      = go & rfl_req & ~ld_force;
    st_gnt       = go & st_req & ~rfl_req & ~ld_force;
    ld_gnt       = go & ld_req & (ld_force | ~(rfl_req | st_req));
    rfl_beat_vld = rfl_gnt | ((state == ST_RFL) & ~cpurst);
    acc          = rfl_beat_vld ? ACC_RFL : st_gnt ? ACC_ST : ld_gnt ? ACC_RD : ACC_IDLE;
    acc_idx      = (acc == ACC_RFL) ? (rfl_gnt ? {rfl_idx[IDX_W-1:2], 2'b00} : {base, beat}) :
                   (acc == ACC_ST) ? st_idx : ld_idx;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state        <= ST_IDLE;
      beat         <= 2'd0;
      base         <= '0;
      rd_p1        <= 1'b0;
      ld_rdata_vld <= 1'b0;
      data_sel_b   <= 1'b1;
      data_gwen_b  <= 1'b1;
      data_wen_b   <= 4'hF;
      data_idx     <= '0;
      data_din     <= '0;
    end else begin
      state        <= rfl_gnt ? ST_RFL : (state == ST_RFL && beat == 2'(RFL_BEATS - 1)) ? ST_IDLE : state;
      beat         <= rfl_gnt ? 2'd1 : (state == ST_RFL) ? beat + 2'd1 : beat;
      base         <= rfl_gnt ? rfl_idx[IDX_W-1:2] : base;
      rd_p1        <= ld_gnt;
      ld_rdata_vld <= rd_p1;
      data_sel_b   <= ~((acc == ACC_RD) | (acc == ACC_RFL) | ((acc == ACC_ST) & (|st_be)));
      data_gwen_b  <= ~((acc == ACC_ST) | (acc == ACC_RFL));
      data_wen_b   <= (acc == ACC_RFL) ? 4'h0 : (acc == ACC_ST) ? ~st_be : 4'hF;
      data_idx     <= (acc != ACC_IDLE) ? acc_idx : data_idx;
      data_din     <= (acc == ACC_RFL) ? rfl_wdata : (acc == ACC_ST) ? st_wdata : data_din;
    end
  end

  assign ld_rdata        = ld_rdata_vld ? data_dout : 32'h0;
  assign data_gateclk_en = rfl_req | st_req | ld_req | (state != ST_IDLE) | ~data_sel_b | rd_p1;
endmodule
